// File: rtl/sobel_pkg.sv
// Shared widths, FSM state type and the squaring helper for the Sobel gradient front end.
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int R_W    = 16;
    localparam int GRAD_W = 11;
    localparam int SQ_W   = 20;
    localparam int SUM_W  = 21;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // |g| <= 1020, so g*g always fits in SQ_W bits once sign-extended.
    function automatic logic [SQ_W-1:0] grad_sq(input logic signed [GRAD_W-1:0] g);
        logic signed [2*GRAD_W-1:0] g_ext;
        g_ext = {{GRAD_W{g[GRAD_W-1]}}, g};
        return SQ_W'(g_ext * g_ext);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image-row delay: dout presents the pixel written DEPTH accepted pixels earlier.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    // The registered read port supplies the last stage of delay, so the array holds DEPTH-1.
    localparam int MEM_D = DEPTH - 1;
    localparam int PTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    logic [PIX_W-1:0] mem [MEM_D];
    logic [PTR_W-1:0] ptr_reg;
    logic [PIX_W-1:0] dout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (we) begin
            ptr_reg <= (ptr_reg == PTR_W'(MEM_D - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            dout_reg     <= mem[ptr_reg];
            mem[ptr_reg] <= din;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/sobel_grad_sq.sv
// Streaming 3x3 Sobel: emits (Gx^2 + Gy^2) >> SHIFT, saturated to 16 bits, for interior pixels.
module sobel_grad_sq
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int SHIFT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [R_W-1:0]   r_out,
    output logic             r_valid,
    output logic             r_last,
    output logic             err_frame
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    state_t           state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next, cur_col;
    logic [ROW_W-1:0] row_reg, row_next, cur_row;
    logic             accept, err_next, win_en, last_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            err_frame <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            err_frame <= err_next;
        end
    end

    // cur_row/cur_col give the position of the pixel being accepted this edge.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        cur_col    = col_reg;
        cur_row    = row_reg;
        accept     = 1'b0;
        err_next   = 1'b0;
        if (pix_valid && sof) begin
            accept   = 1'b1;
            cur_col  = '0;
            cur_row  = '0;
            err_next = (state_reg == RUN);
        end else if (pix_valid && state_reg == RUN) begin
            accept = 1'b1;
        end
        if (accept) begin
            state_next = RUN;
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_next = '0;
                if (cur_row == ROW_W'(IMG_H - 1)) begin
                    row_next   = '0;
                    state_next = IDLE;
                end else begin
                    row_next = cur_row + 1'b1;
                end
            end else begin
                col_next = cur_col + 1'b1;
                row_next = cur_row;
            end
        end
    end

    assign win_en  = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    assign last_en = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));

    logic [PIX_W-1:0] lb1_out, lb2_out;

    sobel_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk (clk),
        .rst (rst),
        .we  (accept),
        .din (pix_in),
        .dout(lb1_out)
    );

    sobel_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk (clk),
        .rst (rst),
        .we  (accept),
        .din (lb1_out),
        .dout(lb2_out)
    );

    // Row 0 of the window is two rows up, row 2 is the current row; column 2 is newest.
    logic [PIX_W-1:0] tap     [3];
    logic [PIX_W-1:0] win_reg [3][3];

    assign tap[0] = lb2_out;
    assign tap[1] = lb1_out;
    assign tap[2] = pix_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            always_ff @(posedge clk) begin
                if (accept) begin
                    win_reg[gi][0] <= win_reg[gi][1];
                    win_reg[gi][1] <= win_reg[gi][2];
                    win_reg[gi][2] <= tap[gi];
                end
            end
        end
    endgenerate

    logic [PIX_W+1:0]         gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GRAD_W-1:0] gx_next, gy_next, gx_reg, gy_reg;
    logic [SQ_W-1:0]          gx_sq_reg, gy_sq_reg;
    logic [SUM_W-1:0]         sum_next, shifted_next;
    logic [R_W-1:0]           r_next;

    assign gx_pos = {2'b0, win_reg[0][2]} + {1'b0, win_reg[1][2], 1'b0} + {2'b0, win_reg[2][2]};
    assign gx_neg = {2'b0, win_reg[0][0]} + {1'b0, win_reg[1][0], 1'b0} + {2'b0, win_reg[2][0]};
    assign gy_pos = {2'b0, win_reg[2][0]} + {1'b0, win_reg[2][1], 1'b0} + {2'b0, win_reg[2][2]};
    assign gy_neg = {2'b0, win_reg[0][0]} + {1'b0, win_reg[0][1], 1'b0} + {2'b0, win_reg[0][2]};
    assign gx_next = {1'b0, gx_pos} - {1'b0, gx_neg};
    assign gy_next = {1'b0, gy_pos} - {1'b0, gy_neg};

    assign sum_next     = {1'b0, gx_sq_reg} + {1'b0, gy_sq_reg};
    assign shifted_next = sum_next >> SHIFT;
    assign r_next       = (|shifted_next[SUM_W-1:R_W]) ? '1 : shifted_next[R_W-1:0];

    always_ff @(posedge clk) begin
        gx_reg    <= gx_next;
        gy_reg    <= gy_next;
        gx_sq_reg <= grad_sq(gx_reg);
        gy_sq_reg <= grad_sq(gy_reg);
    end

    logic [2:0] vld_reg, lst_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
            lst_reg <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            vld_reg <= {vld_reg[1:0], win_en};
            lst_reg <= {lst_reg[1:0], win_en && last_en};
            r_out   <= r_next;
            r_valid <= vld_reg[2];
            r_last  <= lst_reg[2];
        end
    end

endmodule

// File: doc/sobel_grad_sq.md
# sobel_grad_sq

Streaming Sobel front end that sits directly upstream of the approximate square-root stage in the edge-detection datapath. It accepts a raster-order 8-bit grayscale pixel stream and buffers two image rows to form a 3x3 window. For every interior pixel it computes Gx and Gy and emits R = (Gx² + Gy²) >> SHIFT, saturated to 16 bits. R connects unchanged to the 16-bit R input of the square-root stage, whose 8-bit result is the edge magnitude.

## Interface
Parameters:
- IMG_W, 64: pixels per row; minimum 3.
- IMG_H, 64: rows per frame; minimum 3.
- SHIFT, 5: right shift applied to Gx² + Gy². The default 5 maps the maximum sum 2,080,800 to 65,025.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pix_in  in  8  unsigned pixel.
- pix_valid  in  1  pix_in is accepted on a clk edge where this is high. No backpressure.
- sof  in  1  start of frame; qualified by pix_valid and marks pixel (0,0).
- r_out  out  16  scaled squared gradient magnitude.
- r_valid  out  1  r_out is valid this cycle.
- r_last  out  1  high together with r_valid for the last interior pixel of the frame.
- err_frame  out  1  one-cycle pulse when sof arrives mid-frame.

## Operation
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted pixels.
  - col wraps to 0 at IMG_W-1 and increments row.
  - After pixel (IMG_H-1, IMG_W-1) the block returns to IDLE.
- States:
  - IDLE: pixels are ignored until sof arrives with pix_valid.
  - RUN: counters advance on each accepted pixel.
  - sof with pix_valid in IDLE restarts the frame and takes pixel (0,0).
  - sof with pix_valid in RUN pulses err_frame, discards the partial frame, resets the counters and takes the current pixel as (0,0). In-flight pipeline outputs still drain.
- Line buffers: two row delays of depth IMG_W, written on every accepted pixel.
- Window: a 3x3 shift-register window. p00 is the top-left (oldest) tap and p22 is the current pixel.
- Gradients, signed 11-bit:
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20).
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02).
- Magnitude: Gx² and Gy² are unsigned 20-bit values. Their sum is 21 bits. The sum is shifted right by SHIFT with truncation, then saturated to 16'hFFFF if the result exceeds 16 bits.
- Output enable: an output is produced only when the accepted pixel has row ≥ 2 and col ≥ 2. Its centre is (row−1, col−1).
  - Frame border pixels produce no output.
  - Each frame produces (IMG_W−2)·(IMG_H−2) outputs.
- r_last is raised for the output whose enabling pixel is (IMG_H−1, IMG_W−1).

## Timing
- Pipeline after acceptance edge k:
  - edge k: window updated.
  - edge k+1: Gx/Gy registered.
  - edge k+2: squares registered.
  - edge k+3: sum, shift and saturation registered.
- r_valid and r_last are high for exactly the cycle following edge k+3, so latency is 4 edges.
- Gaps in pix_valid insert matching bubbles into r_valid. Back-to-back pixels give one output per cycle.
- Reset values: r_out=0, r_valid=0, r_last=0, err_frame=0. On reset, state goes to IDLE, counters clear and pipeline valid bits clear.
- Line-buffer contents are not reset. They are never read as valid before being rewritten in a new frame.
- Reset mid-frame: no output appears after reset deasserts until a new sof-started frame reaches row 2, col 2.
- err_frame is registered and asserts in the cycle following the offending sof edge.

## Structure
- Package sobel_pkg holds:
  - PIX_W=8, R_W=16, GRAD_W=11, SQ_W=20, SUM_W=21.
  - The state enum {IDLE, RUN}.
- Sub-module sobel_line_buffer: a single row delay of parameter depth, with write-enable on accepted pixels. It is instantiated twice.
- The counters, window, arithmetic pipeline and control stay in sobel_grad_sq.

## Test plan
- Flat frame, IMG_W=8, IMG_H=6, all pixels 100, continuous valid → exactly 24 r_valid pulses.
  - All r_out=0.
  - r_last on the 24th pulse only.
- Vertical step (cols 0–3 = 0, cols 4–7 = 255), SHIFT=5:
  - Outputs centred at col 3 and col 4 have Gx=1020, Gy=0, so r_out=32512.
  - All other outputs are 0.
- Horizontal step with SHIFT=3 → step-row outputs saturate at r_out=65535. Non-step outputs are 0.
- Random pix_valid gaps (about 50% duty) on the vertical-step frame → identical r_out sequence to the continuous case. Each r_valid is exactly 4 edges after its enabling pixel.
- sof reasserted at pixel (3,5) → err_frame pulses once. The following frame yields the full 24 correct outputs, ending with r_last.
- rst asserted mid-frame for 2 cycles → all outputs are 0 during reset. No r_valid appears until a new frame's pixel (2,2) plus 4 edges.
